// File: rtl/sram_port_arb_pkg.sv
// sram_port_arb_pkg: shared types and helpers for the SRAM port arbiter.
package sram_port_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int MaxReq = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arb_rr.sv
// sram_port_arb_rr: combinational round-robin picker. Searches cyclically
// from ptr and returns the first active request as one-hot plus index.
module sram_port_arb_rr
  import sram_port_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int Iw     = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [Iw-1:0]     ptr,
  output logic [NumReq-1:0] gnt,
  output logic [Iw-1:0]     idx
);

  // cyclic scan starting at ptr; first requester found wins
  always_comb begin
    int           c;
    logic [Iw-1:0] ci;
    logic         found;
    c     = 0;
    ci    = '0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (i < NumReq) begin
        c = int'(ptr) + i;
        if (c >= NumReq) c = c - NumReq;
        ci = Iw'(c);
        if (!found && req[ci]) begin
          found   = 1'b1;
          gnt[ci] = 1'b1;
          idx     = ci;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// sram_port_arb: shares one 1-cycle-latency SRAM port between NumReq
// requesters with round-robin, same-cycle grant. Define
// SRAM_PORT_ARB_ZERO_INIT_EN to add the post-reset zeroing sequencer.
module sram_port_arb
  import sram_port_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int Aw     = 14,
  parameter int Dw     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_i,
  output logic [NumReq-1:0]          gnt_o,
  input  logic [NumReq-1:0]          we_i,
  input  logic [NumReq-1:0][Aw-1:0]  addr_i,
  input  logic [NumReq-1:0][Dw-1:0]  wdata_i,
  input  logic [NumReq-1:0][Dw-1:0]  wmask_i,
  output logic [NumReq-1:0]          rvalid_o,
  output logic [Dw-1:0]              rdata_o,
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [Aw-1:0]              sram_addr_o,
  output logic [Dw-1:0]              sram_wdata_o,
  output logic [Dw-1:0]              sram_wmask_o,
  input  logic [Dw-1:0]              sram_rdata_i,
  output logic                       init_done_o
);

  localparam int Iw = idx_w(NumReq);

  arb_state_e        state;
  logic [NumReq-1:0] pick_gnt;
  logic [Iw-1:0]     pick_idx;
  logic [Iw-1:0]     ptr;
  logic              rd_pend;
  logic [Iw-1:0]     rd_idx;
  logic              run;

  sram_port_arb_rr #(
    .NumReq (NumReq),
    .Iw     (Iw)
  ) u_rr (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grants only in RUN and never in a reset cycle; requests stay pending.
  assign run   = (state == RUN) && !rst_i;
  assign gnt_o = run ? pick_gnt : '0;

`ifdef SRAM_PORT_ARB_ZERO_INIT_EN
  arb_state_e    state_nxt;
  logic [Aw-1:0] init_cnt;

  // state register and zeroing address counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // INIT ends once the last word is written; RUN holds until reset
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == '1) state_nxt = RUN;
  end

  assign init_done_o = (state == RUN);
`else
  assign state       = RUN;
  assign init_done_o = 1'b1;
`endif

  // port mux: granted requester's fields, overridden by the zeroing writes
  always_comb begin
    sram_req_o   = |gnt_o;
    sram_we_o    = we_i[pick_idx];
    sram_addr_o  = addr_i[pick_idx];
    sram_wdata_o = wdata_i[pick_idx];
    sram_wmask_o = wmask_i[pick_idx];
`ifdef SRAM_PORT_ARB_ZERO_INIT_EN
    if (state == INIT && !rst_i) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = init_cnt;
      sram_wdata_o = '0;
      sram_wmask_o = '1;
    end
`endif
  end

  // priority pointer and read-return tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr     <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else begin
      rd_pend <= (|gnt_o) && !we_i[pick_idx];
      if (|gnt_o) begin
        rd_idx <= pick_idx;
        ptr    <= (pick_idx == Iw'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // read data is steered by index; a reset cycle drops it
  always_comb begin
    rvalid_o = '0;
    if (rd_pend && !rst_i) rvalid_o[rd_idx] = 1'b1;
  end

  assign rdata_o = sram_rdata_i;

endmodule
